mux_rr_arbiter: RTL and testbench

- Sequences a shared 2:1 mux datapath between two streaming requesters (port 0, port 1).
- Round-robin arbitration with packet locking and a burst cap.
- Drives the mux select and registers the selected stream into one output register with a valid/ready handshake.
- Sits in front of a gate-level 2:1 mux / shared sink in the mux test designs.

---
 rtl/mux_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux datapath.
// Two streaming requesters share one registered output stage. A grant is
// locked for the whole packet, but is forcibly released once MAX_BURST beats
// have been moved. The grant drives the mux select directly.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sel,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d, cnt_inc;
  logic               sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               load_en, xfer0, xfer1;

  // The output register can take a new beat when it is empty or draining this cycle.
  assign load_en   = !out_valid_q || out_ready;
  assign in0_ready = load_en && (state_q == GRANT0);
  assign in1_ready = load_en && (state_q == GRANT1);
  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

  // Grant FSM: picks a port in IDLE, counts beats and releases on last or burst cap.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    cnt_inc    = beat_cnt_q + CNT_W'(1);
    sel_d      = sel_q;

    unique case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = prio_q ? GRANT1 : GRANT0;
        end else if (in0_valid) begin
          state_d = GRANT0;
        end else if (in1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (xfer0) begin
          if (in0_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            prio_d     = 1'b1;
            beat_cnt_d = '0;
            state_d    = in1_valid ? GRANT1 : IDLE;
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      GRANT1: begin
        if (xfer1) begin
          if (in1_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            prio_d     = 1'b0;
            beat_cnt_d = '0;
            state_d    = in0_valid ? GRANT0 : IDLE;
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The select follows the next grant and keeps its previous value through IDLE.
    if (state_d == GRANT1) begin
      sel_d = 1'b1;
    end else if (state_d == GRANT0) begin
      sel_d = 1'b0;
    end
  end

  // Output register: capture the granted beat, or empty out once the sink takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (xfer0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_last_d  = in0_last;
    end else if (xfer1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_last_d  = in1_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any beat held in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter.
// Each port is fed from a source queue; expected output beats are pushed to a
// scoreboard as stimulus is queued, and popped when the sink accepts a beat.
module tb_mux_rr_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in0_ready, in0_last;
  logic [7:0] in0_data;
  logic       in1_valid, in1_ready, in1_last;
  logic [7:0] in1_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       sel, busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];
  int    beat_log[$];

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue one beat on a source port.
  task automatic applyStimulus(input int port, input logic [7:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    if (port == 0) src0_q.push_back(b);
    else           src1_q.push_back(b);
  endtask

  // Record a beat the sink must see next.
  task automatic expectBeat(input logic [7:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Wait for all queued traffic to be consumed, then confirm the block is idle.
  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src0_q.size() > 0 || src1_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(n < budget), 1);
    exp_q.delete();
    src0_q.delete();
    src1_q.delete();
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_out_valid_idle"}, 32'(out_valid), 0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  // Assert reset mid-cycle, check outputs immediately, release on the next negedge.
  task automatic resetDut(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 0);
    checkOutput({tag, "_out_last"}, 32'(out_last), 0);
    checkOutput({tag, "_sel"}, 32'(sel), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_in0_ready"}, 32'(in0_ready), 0);
    checkOutput({tag, "_in1_ready"}, 32'(in1_ready), 0);
    src0_q.delete();
    src1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Source drivers: present the head of each queue, advance after a handshake.
  initial begin
    bit    f0, f1;
    beat_t tmp;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    forever begin
      @(negedge clk);
      f0 = in0_valid && in0_ready;
      f1 = in1_valid && in1_ready;
      @(posedge clk);
      #1;
      if (f0 && rst_n && src0_q.size() > 0) tmp = src0_q.pop_front();
      if (f1 && rst_n && src1_q.size() > 0) tmp = src1_q.pop_front();
      if (src0_q.size() > 0) begin
        in0_valid = 1'b1; in0_data = src0_q[0].data; in0_last = src0_q[0].last;
      end else begin
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
      end
      if (src1_q.size() > 0) begin
        in1_valid = 1'b1; in1_data = src1_q[0].data; in1_last = src1_q[0].last;
      end else begin
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
      end
    end
  end

  // Sink monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_log.push_back(cycle);
      checkOutput("sb_has_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  initial begin
    int gap;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Reset asserted asynchronously in the middle of a cycle
    resetDut("t1_reset");

    // Single three-beat packet on port 0
    @(negedge clk);
    applyStimulus(0, 8'h11, 1'b0); expectBeat(8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0); expectBeat(8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b1); expectBeat(8'h33, 1'b1);
    @(negedge clk);
    checkOutput("t2_ready_not_yet", 32'(in0_ready), 0);
    @(negedge clk);
    checkOutput("t2_ready_after_grant", 32'(in0_ready), 1);
    checkOutput("t2_busy", 32'(busy), 1);
    checkOutput("t2_sel", 32'(sel), 0);
    waitDrain("t2", 60);

    // Port 0 released last, so prio now favours port 1 on a tie
    beat_log.delete();
    @(negedge clk);
    applyStimulus(0, 8'hA0, 1'b0); applyStimulus(0, 8'hA1, 1'b1);
    applyStimulus(1, 8'hB0, 1'b0); applyStimulus(1, 8'hB1, 1'b1);
    expectBeat(8'hB0, 1'b0); expectBeat(8'hB1, 1'b1);
    expectBeat(8'hA0, 1'b0); expectBeat(8'hA1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3a_sel_port1", 32'(sel), 1);
    waitDrain("t3a", 60);
    gap = (beat_log.size() >= 3) ? beat_log[2] - beat_log[1] : -1;
    checkOutput("t3a_handover_gap", 32'(gap), 1);
    checkOutput("t3a_sel_holds_idle", 32'(sel), 0);

    // After reset prio is 0, so port 0 wins the tie
    resetDut("t3_reset");
    beat_log.delete();
    @(negedge clk);
    applyStimulus(0, 8'hA0, 1'b0); applyStimulus(0, 8'hA1, 1'b1);
    applyStimulus(1, 8'hB0, 1'b0); applyStimulus(1, 8'hB1, 1'b1);
    expectBeat(8'hA0, 1'b0); expectBeat(8'hA1, 1'b1);
    expectBeat(8'hB0, 1'b0); expectBeat(8'hB1, 1'b1);
    waitDrain("t3b", 60);
    gap = (beat_log.size() >= 3) ? beat_log[2] - beat_log[1] : -1;
    checkOutput("t3b_handover_gap", 32'(gap), 1);
    checkOutput("t3b_beat_count", 32'(beat_log.size()), 4);
    checkOutput("t3b_sel_holds_idle", 32'(sel), 1);

    // Burst cap of 4 forces a release in the middle of a 6-beat packet
    resetDut("t4_reset");
    @(negedge clk);
    for (int i = 1; i <= 6; i++) applyStimulus(0, 8'(i), (i == 6));
    applyStimulus(1, 8'hF0, 1'b1);
    for (int i = 1; i <= 4; i++) expectBeat(8'(i), 1'b0);
    expectBeat(8'hF0, 1'b1);
    expectBeat(8'h05, 1'b0);
    expectBeat(8'h06, 1'b1);
    waitDrain("t4", 80);

    // Backpressure: sink stalls for three cycles during a grant
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 8'(8'h50 + i), (i == 4));
      expectBeat(8'(8'h50 + i), (i == 4));
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5_stall_valid", 32'(out_valid), 1);
      checkOutput("t5_stall_data", 32'(out_data), 32'h52);
      checkOutput("t5_stall_in0_ready", 32'(in0_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitDrain("t5", 60);

    // Reset after beat 2 of a 4-beat packet, then a fresh port 1 request
    @(negedge clk);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 8'(8'h60 + i), (i == 4));
    expectBeat(8'h61, 1'b0);
    expectBeat(8'h62, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("t6_beat2_on_output", 32'(out_data), 32'h62);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(out_valid), 0);
    checkOutput("t6_rst_out_data", 32'(out_data), 0);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_sel", 32'(sel), 0);
    checkOutput("t6_rst_in0_ready", 32'(in0_ready), 0);
    checkOutput("t6_sb_empty", 32'(exp_q.size()), 0);
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 8'h71, 1'b1);
    expectBeat(8'h71, 1'b1);
    @(negedge clk);
    checkOutput("t6_in1_ready_not_yet", 32'(in1_ready), 0);
    @(negedge clk);
    checkOutput("t6_in1_ready", 32'(in1_ready), 1);
    checkOutput("t6_sel_port1", 32'(sel), 1);
    waitDrain("t6", 60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
